// File: rtl/registre_decalage.sv
// Universal shift register: hold, shift toward LSB/MSB and parallel load, with
// complemented outputs and a saturating shift counter for SerDes framing.
module registre_decalage #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CW-1:0]    cnt,
    output logic             full
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;

    // Counter saturates at WIDTH so it can flag a complete word without wrapping
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Next-state selection
    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        unique case (mode)
            MODE_HOLD: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
            MODE_SHR: begin
                q_nxt   = {sin_msb, q[WIDTH-1:1]};
                cnt_nxt = cnt_inc;
            end
            MODE_SHL: begin
                q_nxt   = {q[WIDTH-2:0], sin_lsb};
                cnt_nxt = cnt_inc;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Cell-style complemented and serial taps follow q with no added latency
    assign qn       = ~q;
    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];
    assign full     = (cnt == CNT_MAX);

endmodule

// File: tb/tb_registre_decalage.sv
// Scoreboard bench for registre_decalage (WIDTH = 8): stimulus queues expected
// states, a monitor pops and compares them against the DUT.
module tb_registre_decalage;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic [1:0]       mode;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             sout_lsb;
    logic             sout_msb;
    logic [CW-1:0]    cnt;
    logic             full;

    registre_decalage #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .d        (d),
        .q        (q),
        .qn       (qn),
        .sout_lsb (sout_lsb),
        .sout_msb (sout_msb),
        .cnt      (cnt),
        .full     (full)
    );

    typedef struct {
        string      name;
        bit         sout_only;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       sl;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sat_q   [8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    logic       sat_out [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Clock held idle until the reset-only check is done
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, expv);
        end
    endtask

    // Monitor: drain every queued expectation whenever the stimulus presents a sample
    always begin
        @(sample_ev);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.sout_only) begin
                check({e.name, ".sout_lsb"}, {7'd0, sout_lsb}, {7'd0, e.sl});
            end else begin
                check({e.name, ".q"},        q,                 e.q);
                check({e.name, ".qn"},       qn,                ~e.q);
                check({e.name, ".cnt"},      {4'd0, cnt},       {4'd0, e.cnt});
                check({e.name, ".full"},     {7'd0, full},      {7'd0, (e.cnt == 4'd8)});
                check({e.name, ".sout_lsb"}, {7'd0, sout_lsb},  {7'd0, e.q[0]});
                check({e.name, ".sout_msb"}, {7'd0, sout_msb},  {7'd0, e.q[7]});
            end
        end
    end

    task automatic push_state(input string nm, input logic [7:0] eq, input logic [3:0] ec);
        exp_t e;
        e.name = nm; e.sout_only = 1'b0; e.q = eq; e.cnt = ec; e.sl = 1'b0;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic push_sout(input string nm, input logic esl);
        exp_t e;
        e.name = nm; e.sout_only = 1'b1; e.q = 8'h00; e.cnt = 4'd0; e.sl = esl;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        mode = 2'b11;
        d    = val;
        tick(1);
    endtask

    initial begin
        clk_en  = 1'b0;
        rst_n   = 1'b0;
        mode    = 2'b00;
        sin_msb = 1'b0;
        sin_lsb = 1'b0;
        d       = 8'h00;

        #3;
        push_state("reset_idle", 8'h00, 4'd0);

        rst_n  = 1'b1;
        mode   = 2'b11;
        d      = 8'hA5;
        clk_en = 1'b1;
        tick(1);
        push_state("load_a5", 8'hA5, 4'd0);

        mode = 2'b01; sin_msb = 1'b1;
        tick(1);
        push_state("shr_a5", 8'hD2, 4'd1);

        load(8'hA5);
        mode = 2'b10; sin_lsb = 1'b0;
        tick(1);
        push_state("shl_a5", 8'h4A, 4'd1);

        load(8'hA5);
        mode = 2'b01; sin_msb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_sout($sformatf("sat_out%0d", i), sat_out[i]);
            tick(1);
            push_state($sformatf("sat_step%0d", i), sat_q[i], 4'(i + 1));
        end
        tick(1);
        push_state("sat_ninth", 8'h00, 4'd8);

        load(8'h3C);
        mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            sin_msb = ~sin_msb;
            sin_lsb = ~sin_lsb;
            tick(1);
            push_state($sformatf("hold%0d", i), 8'h3C, 4'd0);
        end

        load(8'h81);
        mode = 2'b10; sin_lsb = 1'b1;
        tick(1);
        push_state("mixed_shl", 8'h03, 4'd1);
        mode = 2'b01; sin_msb = 1'b0;
        tick(1);
        push_state("mixed_shr", 8'h01, 4'd2);

        load(8'hFF);
        mode = 2'b01; sin_msb = 1'b0;
        tick(3);
        push_state("pre_reset", 8'h1F, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        push_state("async_reset", 8'h00, 4'd0);
        mode = 2'b11; d = 8'h55;
        tick(2);
        push_state("reset_held", 8'h00, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        push_state("post_release_load", 8'h55, 4'd0);

        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
